// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - state_t : FSM state encoding
//   - cls_t   : instruction class produced by the decoder
//   - opcode / funct constants for the supported instruction subset
//   - alu_op codes
//   - one-hot select constants for every datapath mux
//   - wreg_for() : destination-register select from the opcode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_EXEC_MA,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MA,
    CLS_BR,
    CLS_J,
    CLS_ILL
  } cls_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  // Memory address mux
  localparam logic [1:0] SEL_PC      = 2'b01;
  localparam logic [1:0] SEL_ALUOUT  = 2'b10;
  // GPR write-data mux
  localparam logic [1:0] WD_ALUOUT   = 2'b01;
  localparam logic [1:0] WD_MDR      = 2'b10;
  // ALU A-operand mux
  localparam logic [1:0] ALUA_PC     = 2'b01;
  localparam logic [1:0] ALUA_A      = 2'b10;
  // GPR write-register mux
  localparam logic [1:0] WREG_RT     = 2'b01;
  localparam logic [1:0] WREG_RD     = 2'b10;
  // ALU B-operand mux
  localparam logic [3:0] ALUB_B      = 4'b0001;
  localparam logic [3:0] ALUB_4      = 4'b0010;
  localparam logic [3:0] ALUB_IMM    = 4'b0100;
  localparam logic [3:0] ALUB_IMM_SH = 4'b1000;
  // PC next-value mux (upper two inputs are reserved)
  localparam logic [4:0] PC_ALU      = 5'b00001;
  localparam logic [4:0] PC_ALUOUT   = 5'b00010;
  localparam logic [4:0] PC_JUMP     = 5'b00100;

  // R-type instructions write rd, everything else writes rt.
  function automatic logic [1:0] wreg_for(input logic [5:0] op);
    return (op == OP_RTYPE) ? WREG_RD : WREG_RT;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle.
//   Inputs to the controller : opcode, funct, zero, mem_ready
//   Outputs from controller  : mux selects (one-hot), ext_op, alu_op,
//                              write enables, instr_done, illegal
// modport master : the control FSM
// modport slave  : the datapath / memory side
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic [1:0] iord_sel;
  logic [1:0] wdata_sel;
  logic [1:0] alua_sel;
  logic [1:0] wreg_sel;
  logic [3:0] alub_sel;
  logic [4:0] pc_sel;
  logic       ext_op;
  logic [2:0] alu_op;
  logic       pc_we;
  logic       ir_we;
  logic       gpr_we;
  logic       dmem_we;
  logic       mdr_we;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord_sel, wdata_sel, alua_sel, wreg_sel, alub_sel, pc_sel,
           ext_op, alu_op, pc_we, ir_we, gpr_we, dmem_we, mdr_we,
           instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord_sel, wdata_sel, alua_sel, wreg_sel, alub_sel, pc_sel,
           ext_op, alu_op, pc_we, ir_we, gpr_we, dmem_we, mdr_we,
           instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction classifier.
//   i_opcode, i_funct : instruction fields from IR
//   o_cls             : which execution path the FSM takes after DECODE
//   o_illegal         : opcode/funct combination is not supported
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = CLS_ILL;
    case (i_opcode)
      OP_RTYPE: if (i_funct == FN_ADDU || i_funct == FN_SUBU) o_cls = CLS_R;
      OP_ORI,
      OP_LUI:   o_cls = CLS_I;
      OP_LW,
      OP_SW:    o_cls = CLS_MA;
      OP_BEQ:   o_cls = CLS_BR;
      OP_J:     o_cls = CLS_J;
      default:  o_cls = CLS_ILL;
    endcase
    o_illegal = (o_cls == CLS_ILL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state returns to S_RST at once)
//   bus   : mc_ctrl_fsm_if.master -- opcode/funct/zero/mem_ready in,
//           one-hot mux selects, ALU controls and write enables out
// Outputs are decoded combinationally from the state register and the
// live inputs, so dropping into S_RST removes every enable in the same
// instant that rst_n falls.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int RESET_STATE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_ctrl_fsm_if.master   bus
);

  localparam int CNT_W = (RESET_STATE_CYCLES > 2) ? $clog2(RESET_STATE_CYCLES) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_rst_cnt;
  cls_t             w_cls;
  logic             w_illegal;

  mc_ctrl_decode u_decode (
    .i_opcode  (bus.opcode),
    .i_funct   (bus.funct),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // State register and reset-hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_rst_cnt <= '0;
    end else begin
      case (r_state)
        S_RST: begin
          if (int'(r_rst_cnt) >= RESET_STATE_CYCLES - 1) begin
            r_state   <= S_FETCH;
            r_rst_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_cls)
            CLS_R:   r_state <= S_EXEC_R;
            CLS_I:   r_state <= S_EXEC_I;
            CLS_MA:  r_state <= S_EXEC_MA;
            CLS_BR:  r_state <= S_BRANCH;
            CLS_J:   r_state <= S_JUMP;
            default: r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R:  r_state <= S_WB_ALU;
        S_EXEC_I:  r_state <= S_WB_ALU;
        S_WB_ALU:  r_state <= S_FETCH;
        S_EXEC_MA: r_state <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  if (bus.mem_ready) r_state <= S_WB_MEM;
        S_WB_MEM:  r_state <= S_FETCH;
        S_MEM_WR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_JUMP:    r_state <= S_FETCH;
        default:   r_state <= S_RST;
      endcase
    end
  end

  // Output decode. Every select gets a legal one-hot default so the
  // downstream muxes never see all-zero, even in S_RST.
  always_comb begin
    bus.iord_sel   = SEL_PC;
    bus.wdata_sel  = WD_ALUOUT;
    bus.alua_sel   = ALUA_PC;
    bus.wreg_sel   = wreg_for(bus.opcode);
    bus.alub_sel   = ALUB_B;
    bus.pc_sel     = PC_ALU;
    bus.ext_op     = 1'b1;
    bus.alu_op     = ALU_ADD;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.gpr_we     = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.mdr_we     = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        bus.iord_sel = SEL_PC;
        bus.alua_sel = ALUA_PC;
        bus.alub_sel = ALUB_4;
        bus.alu_op   = ALU_ADD;
        bus.pc_sel   = PC_ALU;
        bus.ir_we    = bus.mem_ready;
        bus.pc_we    = bus.mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        bus.alua_sel = ALUA_PC;
        bus.alub_sel = ALUB_IMM_SH;
        bus.ext_op   = 1'b1;
        bus.alu_op   = ALU_ADD;
        bus.illegal  = w_illegal;
      end
      S_EXEC_R: begin
        bus.alua_sel = ALUA_A;
        bus.alub_sel = ALUB_B;
        bus.alu_op   = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_EXEC_I: begin
        bus.alua_sel = ALUA_A;
        bus.alub_sel = ALUB_IMM;
        bus.ext_op   = 1'b0;
        bus.alu_op   = (bus.opcode == OP_LUI) ? ALU_LUI : ALU_OR;
      end
      S_WB_ALU: begin
        bus.wdata_sel  = WD_ALUOUT;
        bus.gpr_we     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXEC_MA: begin
        bus.alua_sel = ALUA_A;
        bus.alub_sel = ALUB_IMM;
        bus.ext_op   = 1'b1;
        bus.alu_op   = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.iord_sel = SEL_ALUOUT;
        bus.mdr_we   = bus.mem_ready;
      end
      S_WB_MEM: begin
        bus.wdata_sel  = WD_MDR;
        bus.gpr_we     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        // Write strobe is held for the whole access; the memory samples
        // it on the cycle it raises mem_ready.
        bus.iord_sel   = SEL_ALUOUT;
        bus.dmem_we    = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_BRANCH: begin
        bus.alua_sel   = ALUA_A;
        bus.alub_sel   = ALUB_B;
        bus.alu_op     = ALU_SUB;
        bus.pc_sel     = PC_ALUOUT;
        bus.pc_we      = bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_sel     = PC_JUMP;
        bus.pc_we      = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: an open-loop driver issues
// instructions with random memory wait states and pushes the expected
// per-instruction summary (latency, enable counts, ALU operation applied
// to register A, write-back routing) into a queue; a negedge monitor
// accumulates what the DUT does and compares when instr_done/illegal fires.
module tb_mc_ctrl_fsm;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  typedef struct {
    int         lat, n_ir, n_pc, n_gpr, n_dmem, n_mdr;
    logic       ill;
    logic [2:0] alu;
    logic [3:0] alub;
    logic       chk_ext;
    logic       ext;
    logic [1:0] wdata, wreg, iord;
    logic [4:0] pc_end;
    logic [5:0] op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm #(.RESET_STATE_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;
  int   n_popped = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];

  logic [4:0] w_en;
  assign w_en = {bus.pc_we, bus.ir_we, bus.gpr_we, bus.dmem_we, bus.mdr_we};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         m_cyc, m_ir, m_pc, m_gpr, m_dmem, m_mdr;
  logic [2:0] m_alu;
  logic [3:0] m_alub;
  logic       m_ext;
  logic [1:0] m_wdata, m_wreg, m_iord;
  logic [6:0] oh_v;
  exp_t       m_e;

  task automatic mon_clear();
    m_cyc = 0; m_ir = 0; m_pc = 0; m_gpr = 0; m_dmem = 0; m_mdr = 0;
    m_alu = 3'd7; m_alub = 4'd0; m_ext = 1'b0;
    m_wdata = 2'd0; m_wreg = 2'd0; m_iord = 2'd0;
  endtask

  always @(negedge clk) begin
    oh_v = {$onehot(bus.iord_sel), $onehot(bus.wdata_sel), $onehot(bus.alua_sel),
            $onehot(bus.wreg_sel), $onehot(bus.alub_sel), $onehot(bus.pc_sel),
            (bus.pc_sel[4:3] == 2'b00)};
    chk("onehot_sel", 32'(oh_v), 32'h7F);
    if (!rst_n || !mon_en) begin
      mon_clear();
    end else begin
      m_cyc++;
      m_ir   += int'(bus.ir_we);
      m_pc   += int'(bus.pc_we);
      m_gpr  += int'(bus.gpr_we);
      m_dmem += int'(bus.dmem_we);
      m_mdr  += int'(bus.mdr_we);
      if (bus.alua_sel == 2'b10) begin
        m_alu = bus.alu_op; m_alub = bus.alub_sel; m_ext = bus.ext_op;
      end
      if (bus.gpr_we) begin m_wdata = bus.wdata_sel; m_wreg = bus.wreg_sel; end
      if (bus.mdr_we || bus.dmem_we) m_iord = bus.iord_sel;
      if (bus.instr_done || bus.illegal) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          n_popped++;
          $display("txn %0d op=%02h lat=%0d ill=%0b", n_popped, m_e.op, m_cyc, bus.illegal);
          chk("latency",   32'(m_cyc),  32'(m_e.lat));
          chk("n_ir_we",   32'(m_ir),   32'(m_e.n_ir));
          chk("n_pc_we",   32'(m_pc),   32'(m_e.n_pc));
          chk("n_gpr_we",  32'(m_gpr),  32'(m_e.n_gpr));
          chk("n_dmem_we", 32'(m_dmem), 32'(m_e.n_dmem));
          chk("n_mdr_we",  32'(m_mdr),  32'(m_e.n_mdr));
          chk("end_kind",  32'({bus.illegal, bus.instr_done}), 32'({m_e.ill, ~m_e.ill}));
          chk("exec_alu_op", 32'(m_alu),  32'(m_e.alu));
          chk("exec_alub",   32'(m_alub), 32'(m_e.alub));
          if (m_e.chk_ext) chk("exec_ext_op", 32'(m_ext), 32'(m_e.ext));
          chk("wb_wdata_sel", 32'(m_wdata), 32'(m_e.wdata));
          chk("wb_wreg_sel",  32'(m_wreg),  32'(m_e.wreg));
          chk("mem_iord_sel", 32'(m_iord),  32'(m_e.iord));
          chk("end_pc_sel",   32'(bus.pc_sel), 32'(m_e.pc_end));
        end
        mon_clear();
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic issue(input int kind, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int fw, input int mw);
    exp_t e;
    logic sched [0:63];
    int   mstart;
    e = '{lat: 0, n_ir: 1, n_pc: 1, n_gpr: 0, n_dmem: 0, n_mdr: 0, ill: 1'b0,
          alu: 3'd7, alub: 4'd0, chk_ext: 1'b0, ext: 1'b0, wdata: 2'd0,
          wreg: 2'd0, iord: 2'd0, pc_end: 5'b00001, op: op};
    case (kind)
      K_ADDU, K_SUBU: begin
        e.lat = 4; e.n_gpr = 1; e.alu = (kind == K_SUBU) ? 3'd1 : 3'd0;
        e.alub = 4'b0001; e.wdata = 2'b01;
      end
      K_ORI, K_LUI: begin
        e.lat = 4; e.n_gpr = 1; e.alu = (kind == K_ORI) ? 3'd2 : 3'd3;
        e.alub = 4'b0100; e.chk_ext = 1'b1; e.ext = 1'b0; e.wdata = 2'b01;
      end
      K_LW: begin
        e.lat = 5 + mw; e.n_gpr = 1; e.n_mdr = 1; e.alu = 3'd0; e.alub = 4'b0100;
        e.chk_ext = 1'b1; e.ext = 1'b1; e.wdata = 2'b10; e.iord = 2'b10;
      end
      K_SW: begin
        e.lat = 4 + mw; e.n_dmem = mw + 1; e.alu = 3'd0; e.alub = 4'b0100;
        e.chk_ext = 1'b1; e.ext = 1'b1; e.iord = 2'b10;
      end
      K_BEQ: begin
        e.lat = 3; e.alu = 3'd1; e.alub = 4'b0001; e.n_pc = 1 + int'(z); e.pc_end = 5'b00010;
      end
      K_J: begin
        e.lat = 3; e.n_pc = 2; e.pc_end = 5'b00100;
      end
      default: begin
        e.lat = 2; e.ill = 1'b1;
      end
    endcase
    e.lat += fw;
    if (e.n_gpr != 0) e.wreg = (op == 6'h00) ? 2'b10 : 2'b01;
    // mem_ready schedule: random where it must not matter, forced in
    // the fetch and data-memory phases.
    for (int k = 0; k < 64; k++) sched[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < fw; k++) sched[k] = 1'b0;
    sched[fw] = 1'b1;
    if (kind == K_LW || kind == K_SW) begin
      mstart = fw + 3;
      for (int k = 0; k < mw; k++) sched[mstart + k] = 1'b0;
      sched[mstart + mw] = 1'b1;
    end
    exp_q.push_back(e);
    n_issued++;
    for (int k = 0; k < e.lat; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.opcode = op; bus.funct = fn; bus.zero = z; mon_en = 1'b1;
      end
      bus.mem_ready = sched[k];
    end
  endtask

  task automatic issue_rand();
    int kind, fw, mw;
    logic [5:0] op, fn;
    kind = $urandom_range(0, 8);
    fn = 6'($urandom_range(0, 63));
    fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    mw = $urandom_range(0, 3);
    case (kind)
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      K_ORI:  op = 6'h0D;
      K_LUI:  op = 6'h0F;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          op = 6'h00;
          while (fn == 6'h21 || fn == 6'h23) fn = 6'($urandom_range(0, 63));
        end else begin
          op = 6'($urandom_range(1, 63));
          while (op == 6'h02 || op == 6'h04 || op == 6'h0D || op == 6'h0F ||
                 op == 6'h23 || op == 6'h2B) op = 6'($urandom_range(1, 63));
        end
      end
    endcase
    issue(kind, op, fn, 1'($urandom_range(0, 1)), fw, mw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_enables", 32'(w_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s_rst_enables", 32'(w_en), 32'd0);
    chk("s_rst_done", 32'({bus.instr_done, bus.illegal}), 32'd0);

    // Directed cases
    issue(K_ADDU, 6'h00, 6'h21, 1'b0, 0, 0);
    issue(K_LW,   6'h23, 6'h00, 1'b0, 0, 2);
    issue(K_BEQ,  6'h04, 6'h00, 1'b0, 0, 0);
    issue(K_BEQ,  6'h04, 6'h00, 1'b1, 0, 0);
    issue(K_ILL,  6'h3F, 6'h00, 1'b0, 0, 0);
    issue(K_SW,   6'h2B, 6'h00, 1'b0, 1, 1);
    issue(K_J,    6'h02, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 80; n++) issue_rand();

    // sw interrupted by reset during MEM_WR
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    bus.opcode = 6'h2B; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    @(posedge clk); #1;                       // DECODE
    @(posedge clk); #1;                       // EXEC_MA
    @(posedge clk); #1 bus.mem_ready = 1'b0;  // MEM_WR, memory stalls
    #2;
    chk("memwr_dmem_we", 32'(bus.dmem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enables", 32'(w_en), 32'd0);
    chk("async_rst_done", 32'(bus.instr_done), 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("held_rst_enables", 32'(w_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("s_rst2_enables", 32'(w_en), 32'd0);
    issue(K_ADDU, 6'h00, 6'h21, 1'b0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("txn_count", 32'(n_popped), 32'(n_issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit; sits directly upstream of the datapath select muxes.
- Decodes opcode/funct from IR and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives one-hot select vectors for the dmem-address, gpr-wdata, alu-a, gpr-wreg, alu-b and pc muxes, plus all write enables.
- Handshakes with memory through mem_ready.

Parameters:
- RESET_STATE_CYCLES, 1, cycles spent in S_RST after rst_n deasserts, before the first FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord_sel  out  2  dmem address: b0=PC, b1=ALUOut
- wdata_sel  out  2  gpr wdata: b0=ALUOut, b1=MDR
- alua_sel  out  2  alu.a: b0=PC, b1=A
- wreg_sel  out  2  gpr wreg: b0=rt, b1=rd
- alub_sel  out  4  alu.b: b0=B, b1=const 4, b2=ext imm, b3=ext imm<<2
- pc_sel  out  5  pc next: b0=ALU result, b1=ALUOut, b2=jump target; b3/b4 reserved, never driven 1
- ext_op  out  1  1=sign-extend, 0=zero-extend
- alu_op  out  3  ADD=0, SUB=1, OR=2, LUI=3
- pc_we, ir_we, gpr_we, dmem_we, mdr_we  out  1 each  write enables
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct

Behaviour:
- Outputs are combinational from the state register plus opcode/funct/zero/mem_ready.
- The state register alone resets asynchronously to S_RST.
- Every select vector is exactly one-hot in every state, including S_RST; all-zero is forbidden because the muxes hold their output on all-zero.
- Don't-care defaults: iord=PC, wdata=ALUOut, alua=PC, alub=B, pc=b0, ext_op=1, alu_op=ADD. All enables are 0 unless listed below.
- wreg_sel is rd when opcode==0, otherwise rt.
- S_RST: all enables 0. Stay RESET_STATE_CYCLES cycles, then go to FETCH.
- FETCH: iord=PC, alua=PC, alub=4, ADD, pc=b0; ir_we=pc_we=mem_ready. Hold while !mem_ready; go to DECODE on ready.
- DECODE: alua=PC, alub=imm<<2, ext sign, ADD (ALUOut captures the branch target). Next state by decode:
  - R with funct 0x21/0x23 -> EXEC_R
  - opcode 0x0D/0x0F -> EXEC_I
  - 0x23/0x2B -> EXEC_MA
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - anything else: illegal=1, go to FETCH.
- EXEC_R: alua=A, alub=B, ADD for funct 0x21, SUB for 0x23 -> WB_ALU.
- EXEC_I: alua=A, alub=imm, ext zero, OR for ori, LUI for lui -> WB_ALU.
- WB_ALU: wdata=ALUOut, gpr_we=1, instr_done=1 -> FETCH.
- EXEC_MA: alua=A, alub=imm, ext sign, ADD -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=ALUOut, mdr_we=mem_ready; hold until ready -> WB_MEM.
- WB_MEM: wdata=MDR, gpr_we=1, instr_done=1 -> FETCH.
- MEM_WR: iord=ALUOut, dmem_we=1 every cycle until ready; instr_done=mem_ready -> FETCH.
- BRANCH: alua=A, alub=B, SUB, pc=b1, pc_we=zero, instr_done=1 -> FETCH.
- JUMP: pc=b2, pc_we=1, instr_done=1 -> FETCH.
- Instruction latency with mem_ready always 1: R/I=4, lw=5, sw=4, beq=3, j=3. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: state returns to S_RST immediately; all enables drop in the same cycle; no partial write completes after the edge.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode/funct constants
  - alu_op codes
  - one-hot select constants (SEL_PC, SEL_ALUOUT, ALUB_4, ...)
- Optional sub-module mc_ctrl_decode: purely combinational opcode/funct -> next-state class + illegal.
- The FSM stays in the top.

Test Plan:
- Reset: rst_n low, then high with mem_ready=1 -> one S_RST cycle; all enables 0; every select one-hot; FETCH asserts ir_we=pc_we=1.
- addu (op 0, funct 0x21), mem_ready=1 -> 4 cycles; EXEC_R alu_op=0, alub_sel=0001; WB_ALU gpr_we=1, wreg_sel=10; instr_done on cycle 4.
- lw (0x23), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with iord_sel=10; mdr_we only on the ready cycle; WB_MEM wdata_sel=10, wreg_sel=01; total 7 cycles.
- beq (0x04) with zero=0, then with zero=1 -> BRANCH pc_sel=00010 both times; pc_we 0 then 1; 3 cycles each.
- Opcode 0x3F -> illegal=1 in DECODE; no gpr_we, dmem_we or pc_we beyond FETCH; next state FETCH.
- sw (0x2B) with rst_n pulsed low in MEM_WR -> dmem_we drops asynchronously with rst_n; FSM restarts at S_RST.
